alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one ALU instance among NUM_REQ requesters. Each requester presents an opcode and two operands through a valid/ready handshake. The arbiter issues the winning request to the ALU as a one-cycle load_en pulse, waits the ALU's fixed latency, and captures alu_out. It then returns the result, tagged with the requester id, on a single valid/ready response channel. It sits between the testbench or upstream agents and the ALU's load_en/opcode/operand_a/operand_b inputs.

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Opcode/operand types shared with the ALU, and the requester/response bundle of alu_arbiter.
package alu_opcodes_pkg;
    typedef logic [3:0] opcode_t;
    typedef bit   [7:0] operand_bit_t;
    typedef logic [7:0] operand_logic_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_AND = 4'd2;
    localparam opcode_t OP_OR  = 4'd3;
    localparam opcode_t OP_XOR = 4'd4;
endpackage

// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
// Once raised, rsp_valid holds together with stable rsp_id/rsp_data until rsp_ready is seen.
// A requester may drop req_valid before it is granted.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import alu_opcodes_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    opcode_t      [NUM_REQ-1:0]    req_opcode;
    operand_bit_t [NUM_REQ-1:0]    req_operand_a;
    operand_bit_t [NUM_REQ-1:0]    req_operand_b;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    operand_logic_t                rsp_data;

    modport master (
        output req_valid, req_opcode, req_operand_a, req_operand_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_opcode, req_operand_a, req_operand_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one fixed-latency ALU among NUM_REQ requesters; round-robin by default,
// lowest-index fixed priority when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arbiter
    import alu_opcodes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           reset,
    alu_arbiter_if.slave   bus,
    output logic           alu_load_en,
    output opcode_t        alu_opcode,
    output operand_bit_t   alu_operand_a,
    output operand_bit_t   alu_operand_b,
    input  operand_logic_t alu_out,
    output logic           busy,
    output logic [1:0]     fsm_state
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    operand_logic_t   rsp_data_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        found  = |bus.req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) winner = ID_W'(i);
        end
    end
`else
    // One extra bit so last_grant + NUM_REQ never overflows before the wrap.
    logic [ID_W:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, last_grant} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end
`endif

    assign bus.req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign fsm_state     = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            alu_load_en   <= 1'b0;
            alu_opcode    <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_opcode    <= bus.req_opcode[winner];
                        alu_operand_a <= bus.req_operand_a[winner];
                        alu_operand_b <= bus.req_operand_b[winner];
                        rsp_id_q      <= winner;
                        last_grant    <= winner;
                        alu_load_en   <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_load_en <= 1'b0;
                    cnt         <= CNT_W'(ALU_LAT);
                    state       <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    // Count of 1 marks the edge where alu_out becomes valid.
                    if (cnt == CNT_W'(1)) begin
                        rsp_data_q  <= alu_out;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural fixed-latency ALU and a response scoreboard.
module tb_alu_arbiter;
    import alu_opcodes_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ALU_LAT = 2;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int EXP_W   = 1 + ID_W + 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           alu_load_en;
    opcode_t        alu_opcode;
    operand_bit_t   alu_operand_a;
    operand_bit_t   alu_operand_b;
    operand_logic_t alu_out;
    logic           busy;
    logic [1:0]     fsm_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [EXP_W-1:0] exp_q[$];
    opcode_t      opc_t [NUM_REQ];
    operand_bit_t a_t   [NUM_REQ];
    operand_bit_t b_t   [NUM_REQ];
    opcode_t      op_tbl [6] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, 4'hF};

    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT), .ID_W(ID_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .alu_load_en(alu_load_en),
        .alu_opcode(alu_opcode),
        .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_out(alu_out),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    function automatic operand_logic_t alu_ref(opcode_t op, operand_bit_t a, operand_bit_t b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a ^ ~b;
        endcase
    endfunction

    // ALU model: result valid only in the cycle ALU_LAT edges after the load edge.
    operand_logic_t     pipe_d [ALU_LAT];
    logic [ALU_LAT-1:0] pipe_v;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= alu_load_en;
            pipe_d[0] <= alu_ref(alu_opcode, alu_operand_a, alu_operand_b);
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end
    assign alu_out = pipe_v[ALU_LAT-1] ? pipe_d[ALU_LAT-1] : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic set_req(input int i, input opcode_t op, input operand_bit_t a, input operand_bit_t b);
        opc_t[i] = op;
        a_t[i]   = a;
        b_t[i]   = b;
        bus.req_opcode[i]    = op;
        bus.req_operand_a[i] = a;
        bus.req_operand_b[i] = b;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic pop_exp(output logic [EXP_W-1:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
    endtask

    task automatic wait_rsp(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            mid();
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        #3;
        total_cnt++;
        if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", bus.req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({alu_load_en, busy, bus.rsp_valid} !== 3'b000)
            $display("FAIL reset_strobes got %b want 000", {alu_load_en, busy, bus.rsp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({alu_opcode, alu_operand_a, alu_operand_b} !== 20'h0)
            $display("FAIL reset_alu_regs got %h want 0", {alu_opcode, alu_operand_a, alu_operand_b});
        else pass_cnt++;
        total_cnt++;
        if ({bus.rsp_id, bus.rsp_data} !== 10'h0)
            $display("FAIL reset_rsp got %h want 0", {bus.rsp_id, bus.rsp_data});
        else pass_cnt++;
        total_cnt++;
        if (fsm_state !== 2'd0) $display("FAIL reset_state got %0d want 0", fsm_state);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [EXP_W-1:0] e;
        apply_reset();
        set_req(1, OP_ADD, 8'd3, 8'd5);
        tick(); bus.req_valid = 4'b0010; mid();
        total_cnt++;
        if (bus.req_ready !== 4'b0010) $display("FAIL single_grant got %b want 0010", bus.req_ready);
        else pass_cnt++;
        exp_q.push_back({1'b1, 2'd1, 8'd8});
        tick(); bus.req_valid = '0; mid();
        total_cnt++;
        if ({alu_load_en, alu_opcode, alu_operand_a, alu_operand_b} !== {1'b1, OP_ADD, 8'd3, 8'd5})
            $display("FAIL single_issue got %h want %h", {alu_load_en, alu_opcode, alu_operand_a, alu_operand_b},
                     {1'b1, OP_ADD, 8'd3, 8'd5});
        else pass_cnt++;
        for (int c = 2; c <= 3; c++) begin
            tick(); mid();
            total_cnt++;
            if ({alu_load_en, bus.rsp_valid, busy} !== 3'b001)
                $display("FAIL single_wait_c%0d got %b want 001", c, {alu_load_en, bus.rsp_valid, busy});
            else pass_cnt++;
        end
        tick(); mid();
        pop_exp(e);
        total_cnt++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== e)
            $display("FAIL single_rsp got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, e);
        else pass_cnt++;
        tick(); mid();
        total_cnt++;
        if ({busy, bus.rsp_valid} !== 2'b00) $display("FAIL single_idle got %b want 00", {busy, bus.rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [EXP_W-1:0]   e;
        logic [NUM_REQ-1:0] exp_oh;
        int exp_last;
        int exp_w;
        int k;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, op_tbl[$urandom_range(0, 5)], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        exp_last = NUM_REQ - 1;
        k = 0;
        tick(); bus.req_valid = 4'hF; mid();
        for (int c = 0; c < 25; c++) begin
            if (c > 0) begin tick(); mid(); end
            if (bus.req_ready !== 4'b0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                exp_w = 0;
`else
                exp_w = (exp_last + 1) % NUM_REQ;
`endif
                exp_oh = '0;
                exp_oh[exp_w] = 1'b1;
                total_cnt++;
                if (bus.req_ready !== exp_oh) $display("FAIL rr_grant%0d got %b want %b", k, bus.req_ready, exp_oh);
                else pass_cnt++;
                total_cnt++;
                if (c !== k * (ALU_LAT + 3)) $display("FAIL rr_spacing%0d got cycle %0d want %0d", k, c, k * (ALU_LAT + 3));
                else pass_cnt++;
                exp_q.push_back({1'b1, ID_W'(exp_w), alu_ref(opc_t[exp_w], a_t[exp_w], b_t[exp_w])});
                exp_last = exp_w;
                k++;
            end
            if (bus.rsp_valid === 1'b1) begin
                pop_exp(e);
                total_cnt++;
                if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== e)
                    $display("FAIL rr_rsp got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, e);
                else pass_cnt++;
            end
        end
        tick(); bus.req_valid = '0;
        total_cnt++;
        if (k !== 5) $display("FAIL rr_grant_count got %0d want 5", k);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [EXP_W-1:0] e;
        bit seen;
        apply_reset();
        set_req(0, OP_SUB, 8'd10, 8'd4);
        set_req(2, OP_XOR, 8'hA5, 8'h0F);
        bus.rsp_ready = 1'b0;
        tick(); bus.req_valid = 4'b0101; mid();
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL stall_grant0 got %b want 0001", bus.req_ready);
        else pass_cnt++;
        exp_q.push_back({1'b1, 2'd0, 8'd6});
        tick(); bus.req_valid = 4'b0100;
        tick();
        tick();
        for (int c = 4; c < 10; c++) begin
            tick(); mid();
            total_cnt++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready} !== {1'b1, 2'd0, 8'd6, 4'b0000})
                $display("FAIL stall_hold_c%0d got %h want %h", c,
                         {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready}, {1'b1, 2'd0, 8'd6, 4'b0000});
            else pass_cnt++;
        end
        tick(); bus.rsp_ready = 1'b1; mid();
        pop_exp(e);
        total_cnt++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== e)
            $display("FAIL stall_rsp got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, e);
        else pass_cnt++;
        tick(); mid();
        total_cnt++;
        if (bus.req_ready !== 4'b0100) $display("FAIL stall_next_grant got %b want 0100", bus.req_ready);
        else pass_cnt++;
        exp_q.push_back({1'b1, 2'd2, 8'hAA});
        tick(); bus.req_valid = '0;
        wait_rsp(12, seen);
        total_cnt++;
        if (!seen) $display("FAIL stall_rsp2_timeout got none want rsp_valid");
        else pass_cnt++;
        pop_exp(e);
        total_cnt++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== e)
            $display("FAIL stall_rsp2 got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        logic [EXP_W-1:0] e;
        bit seen;
        int rsp_cnt;
        apply_reset();
        set_req(1, OP_ADD, 8'd20, 8'd22);
        set_req(0, OP_AND, 8'hF0, 8'h3C);
        set_req(3, OP_OR, 8'h01, 8'h80);
        tick(); bus.req_valid = 4'b0010; mid();
        total_cnt++;
        if (bus.req_ready !== 4'b0010) $display("FAIL rstw_grant1 got %b want 0010", bus.req_ready);
        else pass_cnt++;
        tick(); bus.req_valid = '0;
        tick();
        total_cnt++;
        if (fsm_state !== 2'd2) $display("FAIL rstw_in_wait got %0d want 2", fsm_state);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({bus.req_ready, alu_load_en, alu_opcode, alu_operand_a, alu_operand_b, bus.rsp_valid, bus.rsp_id,
             bus.rsp_data, busy, fsm_state} !== 40'h0)
            $display("FAIL rstw_async_clear got %h want 0", {bus.req_ready, alu_load_en, alu_opcode, alu_operand_a,
                     alu_operand_b, bus.rsp_valid, bus.rsp_id, bus.rsp_data, busy, fsm_state});
        else pass_cnt++;
        rsp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick(); mid();
            if (bus.rsp_valid !== 1'b0) rsp_cnt++;
        end
        tick(); reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(); mid();
            if (bus.rsp_valid !== 1'b0) rsp_cnt++;
        end
        total_cnt++;
        if (rsp_cnt !== 0) $display("FAIL rstw_no_rsp got %0d responses want 0", rsp_cnt);
        else pass_cnt++;
        tick(); bus.req_valid = 4'b1001; mid();
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL rstw_first_grant got %b want 0001", bus.req_ready);
        else pass_cnt++;
        exp_q.push_back({1'b1, 2'd0, 8'h30});
        tick(); bus.req_valid = '0;
        wait_rsp(12, seen);
        total_cnt++;
        if (!seen) $display("FAIL rstw_rsp_timeout got none want rsp_valid");
        else pass_cnt++;
        pop_exp(e);
        total_cnt++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== e)
            $display("FAIL rstw_rsp got %h want %h", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, e);
        else pass_cnt++;
    endtask

    task automatic test_withdrawn();
        logic [EXP_W-1:0] e;
        int loads;
        int g2;
        apply_reset();
        set_req(0, OP_OR, 8'h12, 8'h21);
        set_req(2, OP_ADD, 8'd1, 8'd1);
        tick(); bus.req_valid = 4'b0001; mid();
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL wd_grant0 got %b want 0001", bus.req_ready);
        else pass_cnt++;
        exp_q.push_back({1'b1, 2'd0, 8'h33});
        tick(); bus.req_valid = '0;
        tick(); bus.req_valid = 4'b0100; mid();
        loads = (alu_load_en !== 1'b0) ? 1 : 0;
        g2    = (bus.req_ready[2] !== 1'b0) ? 1 : 0;
        tick(); bus.req_valid = '0; mid();
        if (alu_load_en !== 1'b0) loads++;
        if (bus.req_ready[2] !== 1'b0) g2++;
        tick(); mid();
        pop_exp(e);
        total_cnt++;
        if ({bus.rsp_valid, busy, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, e[ID_W+7:0]})
            $display("FAIL wd_rsp got %h want %h", {bus.rsp_valid, busy, bus.rsp_id, bus.rsp_data},
                     {1'b1, 1'b1, e[ID_W+7:0]});
        else pass_cnt++;
        tick(); mid();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL wd_busy_fall got %b want 0", busy);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            if (alu_load_en !== 1'b0) loads++;
            if (bus.req_ready[2] !== 1'b0) g2++;
            tick(); mid();
        end
        total_cnt++;
        if (loads !== 0) $display("FAIL wd_spurious_load got %0d want 0", loads);
        else pass_cnt++;
        total_cnt++;
        if (g2 !== 0) $display("FAIL wd_grant2 got %0d want 0", g2);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) set_req(i, OP_ADD, 8'd0, 8'd0);
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid_wait();
        test_withdrawn();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
